ram_sdp_clr: RTL and testbench

- Parametrised simple-dual-port RAM: one write port, one read port, single clock.
- Additions over a plain RAM:
  - per-byte write enables;
  - registered read with a valid strobe;
  - selectable read-during-write behaviour;
  - hardware clear sequencer that sweeps every location to a known value after reset or on request.
- Used as a scratch/buffer memory by datapath blocks. Consumers hold off on busy.

---
 rtl/ram_sdp_clr.sv | 152 +++++++++++++++
 tb/tb_ram_sdp_clr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with per-byte write enables, registered read with a valid
// strobe, selectable read-during-write behaviour and a hardware clear sweeper.
module ram_sdp_clr #(
    parameter int                 DATA_W  = 16,
    parameter int                 BYTE_W  = 8,
    parameter int                 ADDR_W  = 4,
    parameter int                 DEPTH   = 16,
    parameter int                 RD_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W/BYTE_W-1:0]   wbe,
    input  logic [DATA_W-1:0]          din,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_vld
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    if (DATA_W % BYTE_W != 0) begin : g_bad_lanes
        $error("ram_sdp_clr: DATA_W must be a multiple of BYTE_W");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("ram_sdp_clr: DEPTH must lie in 1..2**ADDR_W");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              waddr_ok, raddr_ok, same_addr;
    logic [IDX_W-1:0]  widx, ridx, cidx;
    logic [DATA_W-1:0] wr_word_p0, rd_word_p0;
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;

    // Replace the enabled byte lanes of a stored word with the incoming lanes.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input logic [LANES-1:0]  be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

    // Stage p0: address decode and word assembly
    assign waddr_ok  = ({1'b0, waddr} < DEPTH_C);
    assign raddr_ok  = ({1'b0, raddr} < DEPTH_C);
    assign same_addr = we && waddr_ok && (waddr == raddr);
    assign widx      = IDX_W'(waddr);
    assign ridx      = IDX_W'(raddr);
    assign cidx      = IDX_W'(cnt);

    assign wr_word_p0 = merge_lanes(mem[widx], din, wbe);

    always_comb begin
        rd_word_p0 = mem[ridx];
        if (!raddr_ok) begin
            rd_word_p0 = CLR_VAL;
        end else if ((RD_MODE != 0) && same_addr) begin
            rd_word_p0 = wr_word_p0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (clr) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST_C) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Storage has no reset; the sweep counter never exceeds DEPTH-1 while clearing.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cidx] <= CLR_VAL;
        end else if (we && waddr_ok) begin
            mem[widx] <= wr_word_p0;
        end
    end

    // Stage p1: registered read data and strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (state == READY && re) begin
                vld_p1  <= 1'b1;
                dout_p1 <= rd_word_p0;
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign dout     = dout_p1;
    assign dout_vld = vld_p1;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: three instances (read-first, write-through, DEPTH=12)
// share stimulus; a reference model feeds per-instance read scoreboards.
module tb_ram_sdp_clr;

    logic        clk, rst, clr, we, re;
    logic [3:0]  waddr, raddr;
    logic [1:0]  wbe;
    logic [15:0] din;
    logic        busy_a [3];
    logic        vld_a  [3];
    logic [15:0] dout_a [3];

    int checks = 0;
    int errors = 0;

    ram_sdp_clr u_rf (.clk(clk), .rst(rst), .clr(clr), .busy(busy_a[0]), .we(we), .waddr(waddr),
                      .wbe(wbe), .din(din), .re(re), .raddr(raddr), .dout(dout_a[0]), .dout_vld(vld_a[0]));
    ram_sdp_clr #(.RD_MODE(1)) u_wt (.clk(clk), .rst(rst), .clr(clr), .busy(busy_a[1]), .we(we),
                      .waddr(waddr), .wbe(wbe), .din(din), .re(re), .raddr(raddr), .dout(dout_a[1]),
                      .dout_vld(vld_a[1]));
    ram_sdp_clr #(.DEPTH(12)) u_d12 (.clk(clk), .rst(rst), .clr(clr), .busy(busy_a[2]), .we(we),
                      .waddr(waddr), .wbe(wbe), .din(din), .re(re), .raddr(raddr), .dout(dout_a[2]),
                      .dout_vld(vld_a[2]));

    always #5 clk = ~clk;

    // reference model state
    logic [15:0] m_mem  [3][16];
    logic        m_busy [3];
    int          m_cnt  [3];
    logic        m_vld  [3];
    logic [15:0] m_dout [3];
    int          m_depth[3];
    bit          m_mode [3];
    logic [15:0] q0[$], q1[$], q2[$];

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [1:0]  wbe;
        logic [15:0] din;
        logic        re;
        logic [3:0]  raddr;
        logic        chk;
        logic [15:0] e0, e1, e2;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int i, input logic [15:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_pop(input int i, output logic [15:0] v);
        case (i)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    function automatic logic [15:0] lane_mix(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b1;
            m_cnt[i]  = 0;
            m_vld[i]  = 1'b0;
            m_dout[i] = 16'h0000;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Advance the model on the current inputs, clock once, then compare at the falling edge.
    task automatic cyc();
        logic [15:0] rd, got;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b1; m_cnt[i] = 0; m_vld[i] = 1'b0; m_dout[i] = 16'h0000;
            end else if (m_busy[i]) begin
                m_mem[i][m_cnt[i]] = 16'h0000;
                m_vld[i] = 1'b0;
                if (clr) m_cnt[i] = 0;
                else if (m_cnt[i] == m_depth[i] - 1) m_busy[i] = 1'b0;
                else m_cnt[i]++;
            end else begin
                m_vld[i] = re;
                if (re) begin
                    if (int'(raddr) >= m_depth[i]) rd = 16'h0000;
                    else begin
                        rd = m_mem[i][raddr];
                        if (m_mode[i] && we && waddr == raddr) rd = lane_mix(rd, din, wbe);
                    end
                    sb_push(i, rd);
                end
                if (we && int'(waddr) < m_depth[i]) m_mem[i][waddr] = lane_mix(m_mem[i][waddr], din, wbe);
                if (clr) begin m_busy[i] = 1'b1; m_cnt[i] = 0; end
            end
        end
        if (rst) begin q0.delete(); q1.delete(); q2.delete(); end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("busy", i, 16'(busy_a[i]), 16'(m_busy[i]));
            chk("vld", i, 16'(vld_a[i]), 16'(m_vld[i]));
            if (vld_a[i] === 1'b1) begin
                if (sb_size(i) == 0) begin
                    chk("sb_empty", i, 16'(sb_size(i)), 16'd1);
                end else begin
                    sb_pop(i, got);
                    m_dout[i] = got;
                end
            end else if (sb_size(i) != 0) begin
                sb_pop(i, got);
            end
            chk("dout", i, dout_a[i], m_dout[i]);
        end
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic run_sweep(input int clr_at, input bit rnd, input int exp0, input int exp2);
        int n0, n2;
        n0 = 0; n2 = 0;
        for (int e = 1; e <= 60 && (n0 == 0 || n2 == 0); e++) begin
            clr = (e == clr_at);
            if (rnd) begin
                we = 1'($urandom); re = 1'($urandom); wbe = 2'($urandom);
                waddr = 4'($urandom); raddr = 4'($urandom); din = 16'($urandom);
            end
            cyc();
            if (n0 == 0 && busy_a[0] === 1'b0) n0 = e;
            if (n2 == 0 && busy_a[2] === 1'b0) n2 = e;
        end
        idle();
        chk("sweep_len", 0, 16'(n0), 16'(exp0));
        chk("sweep_len", 2, 16'(n2), 16'(exp2));
    endtask

    task automatic read_all(input bit zero0);
        for (int a = 0; a < 16; a++) begin
            we = 1'b0; re = 1'b1; raddr = 4'(a);
            cyc();
            if (zero0) chk("clr_rd", 0, dout_a[0], 16'h0000);
        end
        re = 1'b0;
    endtask

    task automatic chk_reset_now(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_busy"}, i, 16'(busy_a[i]), 16'd1);
            chk({tag, "_vld"}, i, 16'(vld_a[i]), 16'd0);
            chk({tag, "_dout"}, i, dout_a[i], 16'h0000);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wbe = '0; din = '0;
        m_depth[0] = 16; m_depth[1] = 16; m_depth[2] = 12;
        m_mode[0] = 1'b0; m_mode[1] = 1'b1; m_mode[2] = 1'b0;
        model_reset_all();

        //            we waddr  wbe    din      re raddr  chk  e0        e1        e2
        tbl[0]  = '{1'b1, 4'd3,  2'b11, 16'hA5A5, 1'b0, 4'd0,  1'b0, 16'h0,    16'h0,    16'h0};
        tbl[1]  = '{1'b1, 4'd3,  2'b01, 16'h1234, 1'b0, 4'd0,  1'b0, 16'h0,    16'h0,    16'h0};
        tbl[2]  = '{1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd3,  1'b1, 16'hA534, 16'hA534, 16'hA534};
        tbl[3]  = '{1'b1, 4'd3,  2'b00, 16'hFFFF, 1'b0, 4'd0,  1'b0, 16'h0,    16'h0,    16'h0};
        tbl[4]  = '{1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd3,  1'b1, 16'hA534, 16'hA534, 16'hA534};
        tbl[5]  = '{1'b1, 4'd5,  2'b11, 16'h1111, 1'b0, 4'd0,  1'b0, 16'h0,    16'h0,    16'h0};
        tbl[6]  = '{1'b1, 4'd5,  2'b11, 16'h2222, 1'b1, 4'd5,  1'b1, 16'h1111, 16'h2222, 16'h1111};
        tbl[7]  = '{1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd5,  1'b1, 16'h2222, 16'h2222, 16'h2222};
        tbl[8]  = '{1'b1, 4'd13, 2'b11, 16'hBEEF, 1'b0, 4'd0,  1'b0, 16'h0,    16'h0,    16'h0};
        tbl[9]  = '{1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd13, 1'b1, 16'hBEEF, 16'hBEEF, 16'h0000};
        tbl[10] = '{1'b0, 4'd0,  2'b00, 16'h0,    1'b1, 4'd12, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        tbl[11] = '{1'b1, 4'd7,  2'b10, 16'h9900, 1'b1, 4'd7,  1'b1, 16'h0000, 16'h9900, 16'h0000};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset_all();
        chk_reset_now("reset");
        rst = 1'b0;
        run_sweep(0, 1'b0, 16, 12);
        read_all(1'b1);

        foreach (tbl[k]) begin
            we = tbl[k].we; waddr = tbl[k].waddr; wbe = tbl[k].wbe; din = tbl[k].din;
            re = tbl[k].re; raddr = tbl[k].raddr;
            cyc();
            if (tbl[k].chk) begin
                chk("tbl_vld", k, 16'(vld_a[0]), 16'd1);
                chk("tbl_rf", k, dout_a[0], tbl[k].e0);
                chk("tbl_wt", k, dout_a[1], tbl[k].e1);
                chk("tbl_d12", k, dout_a[2], tbl[k].e2);
            end
        end
        idle();
        read_all(1'b0);

        // fill with ones, then clear with a same-cycle read and write
        for (int a = 0; a < 16; a++) begin
            we = 1'b1; wbe = 2'b11; waddr = 4'(a); din = 16'hFFFF;
            cyc();
        end
        we = 1'b1; waddr = 4'd1; din = 16'h1357; re = 1'b1; raddr = 4'd0; clr = 1'b1;
        cyc();
        chk("clr_rd_same", 0, dout_a[0], 16'hFFFF);
        run_sweep(0, 1'b1, 16, 12);
        read_all(1'b1);

        clr = 1'b1;
        cyc();
        run_sweep(7, 1'b0, 23, 19);

        // reset during a sweep
        we = 1'b1; waddr = 4'd2; wbe = 2'b11; din = 16'h5A5A;
        cyc();
        we = 1'b0; re = 1'b1; raddr = 4'd2;
        cyc();
        chk("pre_rst", 0, dout_a[0], 16'h5A5A);
        re = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (4) cyc();
        #2 rst = 1'b1;
        #1 chk_reset_now("rst_sweep");
        cyc();
        rst = 1'b0;
        run_sweep(0, 1'b0, 16, 12);

        // reset while a read strobe is being presented
        we = 1'b1; waddr = 4'd4; wbe = 2'b11; din = 16'h7777;
        cyc();
        we = 1'b0; re = 1'b1; raddr = 4'd4;
        cyc();
        chk("pre_rst_rd", 0, dout_a[0], 16'h7777);
        re = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_now("rst_read");
        cyc();
        rst = 1'b0;
        run_sweep(0, 1'b0, 16, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
